// File: rtl/smvm_pkg.sv
// Shared constants and state encoding for the SMVM issue scheduler.
package smvm_pkg;

    localparam int K          = 4;   // lanes per batch
    localparam int VAL_W      = 8;   // signed matrix value width
    localparam int COL_W      = 7;   // column index width
    localparam int PIPE_DEPTH = 4;   // tree latency, issue to result
    localparam int BCNT_W     = 8;   // batch counter width

    // Derived widths
    localparam int CNT_W   = (K > 1) ? $clog2(K) : 1;
    localparam int DRAIN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam int ONES_W  = $clog2(K + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/ipv_popcount.sv
// Population count of a K-bit IPV vector; also used by the output reducer.
module ipv_popcount #(
    parameter int N     = 4,
    parameter int OUT_W = $clog2(N + 1)
) (
    input  logic [N-1:0]     i_bits,
    output logic [OUT_W-1:0] o_count
);

    // Sum the set bits of the input vector.
    always_comb begin
        // NOTE: a default at the top of every always_comb keeps every path assigned, so no latch is inferred.
        o_count = '0;
        for (int i = 0; i < N; i++) begin
            o_count = o_count + OUT_W'(i_bits[i]);
        end
    end

endmodule

// File: rtl/smvm_issue_scheduler.sv
// Packs nonzero entries into K-lane batches, issues them to the multiply/reduce
// tree with a valid/ready handshake, then drains the tree before signalling done.
module smvm_issue_scheduler
    import smvm_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   nnz_valid,
    output logic                   nnz_ready,
    input  logic [VAL_W-1:0]       nnz_val,
    input  logic [COL_W-1:0]       nnz_col,
    input  logic                   nnz_ipv,
    input  logic                   nnz_last,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [K*VAL_W-1:0]     issue_val,
    output logic [K*COL_W-1:0]     issue_col,
    output logic [K-1:0]           issue_ipv,
    output logic [ONES_W-1:0]      issue_ones,
    output logic [BCNT_W-1:0]      batch_count,
    output logic                   busy,
    output logic                   done
);

    state_e                      r_state;
    state_e                      w_next_state;
    logic [CNT_W-1:0]            r_cnt;
    logic [DRAIN_W-1:0]          r_drain_cnt;
    logic [K-1:0][VAL_W-1:0]     r_lane_val;
    logic [K-1:0][COL_W-1:0]     r_lane_col;
    logic [K-1:0]                r_lane_ipv;
    logic [BCNT_W-1:0]           r_batch_count;
    logic                        r_last_seen;

    logic                        w_start;
    logic                        w_accept;
    logic                        w_fire;
    logic                        w_batch_full;
    logic                        w_drain_end;
    logic [K-1:0]                w_issue_ipv;

    // Handshake strobes; each is qualified by the only state that may act on it,
    // so start outside IDLE and nnz_valid outside FILL have no effect.
    assign w_start      = (r_state == ST_IDLE)  && start;
    assign w_accept     = (r_state == ST_FILL)  && nnz_valid;
    assign w_fire       = (r_state == ST_ISSUE) && issue_ready;
    assign w_batch_full = (r_cnt == CNT_W'(K - 1));
    assign w_drain_end  = (r_drain_cnt == DRAIN_W'(PIPE_DEPTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_accept && (w_batch_full || nnz_last)) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue_ready) begin
                    w_next_state = r_last_seen ? ST_DRAIN : ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (w_drain_end) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Lane registers, lane count, end-of-matrix flag and batch counter.
    always_ff @(posedge clk) begin
        // NOTE: the lane registers are reset along with the control state so a partial batch never survives reset.
        if (!rst_n) begin
            r_cnt         <= '0;
            r_lane_val    <= '0;
            r_lane_col    <= '0;
            r_lane_ipv    <= '0;
            r_batch_count <= '0;
            r_last_seen   <= 1'b0;
        end else begin
            if (w_start) begin
                r_cnt         <= '0;
                r_lane_val    <= '0;
                r_lane_col    <= '0;
                r_lane_ipv    <= '0;
                r_batch_count <= '0;
                r_last_seen   <= 1'b0;
            end
            if (w_accept) begin
                r_lane_val[r_cnt] <= nnz_val;
                r_lane_col[r_cnt] <= nnz_col;
                r_lane_ipv[r_cnt] <= nnz_ipv;
                r_cnt             <= w_batch_full ? '0 : r_cnt + CNT_W'(1);
                r_last_seen       <= r_last_seen | nnz_last;
            end
            if (w_fire) begin
                r_cnt      <= '0;
                r_lane_val <= '0;
                r_lane_col <= '0;
                r_lane_ipv <= '0;
                if (r_batch_count != {BCNT_W{1'b1}}) begin
                    r_batch_count <= r_batch_count + BCNT_W'(1);
                end
            end
            if (r_state == ST_DONE) begin
                r_last_seen <= 1'b0;
            end
        end
    end

    // Drain counter: counts tree pipeline cycles after the final issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drain_cnt <= '0;
        end else if (r_state == ST_DRAIN) begin
            r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
        end else begin
            r_drain_cnt <= '0;
        end
    end

    // Lane outputs are presented only while a batch is offered to the tree.
    assign w_issue_ipv = issue_valid ? r_lane_ipv : '0;
    assign issue_val   = issue_valid ? r_lane_val : '0;
    assign issue_col   = issue_valid ? r_lane_col : '0;
    assign issue_ipv   = w_issue_ipv;

    assign nnz_ready   = (r_state == ST_FILL);
    assign issue_valid = (r_state == ST_ISSUE);
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign batch_count = r_batch_count;

    ipv_popcount #(
        .N     (K),
        .OUT_W (ONES_W)
    ) u_ipv_popcount (
        .i_bits  (w_issue_ipv),
        .o_count (issue_ones)
    );

endmodule

// File: tb/tb_smvm_issue_scheduler.sv
// Randomized self-checking bench for smvm_issue_scheduler against a
// batch-level reference model (entry list chopped into K-wide padded batches).
module tb_smvm_issue_scheduler;
    import smvm_pkg::*;

    localparam int MAXN   = 1100;
    localparam int BUDGET = 20000;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic                  nnz_valid;
    logic                  nnz_ready;
    logic [VAL_W-1:0]      nnz_val;
    logic [COL_W-1:0]      nnz_col;
    logic                  nnz_ipv;
    logic                  nnz_last;
    logic                  issue_valid;
    logic                  issue_ready;
    logic [K*VAL_W-1:0]    issue_val;
    logic [K*COL_W-1:0]    issue_col;
    logic [K-1:0]          issue_ipv;
    logic [ONES_W-1:0]     issue_ones;
    logic [BCNT_W-1:0]     batch_count;
    logic                  busy;
    logic                  done;

    int n_checks = 0;
    int n_errors = 0;

    logic [VAL_W-1:0] e_val [MAXN];
    logic [COL_W-1:0] e_col [MAXN];
    logic             e_ipv [MAXN];

    smvm_issue_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .nnz_valid   (nnz_valid),
        .nnz_ready   (nnz_ready),
        .nnz_val     (nnz_val),
        .nnz_col     (nnz_col),
        .nnz_ipv     (nnz_ipv),
        .nnz_last    (nnz_last),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_val   (issue_val),
        .issue_col   (issue_col),
        .issue_ipv   (issue_ipv),
        .issue_ones  (issue_ones),
        .batch_count (batch_count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            e_val[i] = VAL_W'($urandom);
            e_col[i] = COL_W'($urandom);
            e_ipv[i] = 1'($urandom);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_nnz_ready"},   64'(nnz_ready),   64'(0));
        check({tag, "_issue_valid"}, 64'(issue_valid), 64'(0));
        check({tag, "_issue_val"},   64'(issue_val),   64'(0));
        check({tag, "_issue_col"},   64'(issue_col),   64'(0));
        check({tag, "_issue_ipv"},   64'(issue_ipv),   64'(0));
        check({tag, "_issue_ones"},  64'(issue_ones),  64'(0));
        check({tag, "_batch_count"}, 64'(batch_count), 64'(0));
        check({tag, "_busy"},        64'(busy),        64'(0));
        check({tag, "_done"},        64'(done),        64'(0));
    endtask

    // Run one matrix of n entries. pv/pr are percent probabilities of nnz_valid
    // and issue_ready; hold forces issue_ready low for the first hold ISSUE cycles.
    task automatic run_matrix(input int n, input int pv, input int pr, input int hold_cycles);
        logic [K*VAL_W-1:0] q_val [$];
        logic [K*COL_W-1:0] q_col [$];
        logic [K-1:0]       q_ipv [$];
        int                 q_ones [$];
        logic [K*VAL_W-1:0] v;
        logic [K*COL_W-1:0] c;
        logic [K-1:0]       p;
        int                 ones;
        int                 j;
        int                 nb;
        int                 cyc;
        int                 idx;
        int                 fired;
        int                 last_fire;
        int                 hold;
        int                 exp_bc;
        bit                 pending;
        bit                 fin;
        bit                 exp_ready;
        bit                 exp_done;
        bit                 accepted;
        bit                 fire;

        // Reference: entries in order, chopped into K-wide batches, tail padded with zeros.
        nb = (n + K - 1) / K;
        for (int b = 0; b < nb; b++) begin
            v = '0; c = '0; p = '0; ones = 0;
            for (int i = 0; i < K; i++) begin
                j = b * K + i;
                if (j < n) begin
                    v[VAL_W*i +: VAL_W] = e_val[j];
                    c[COL_W*i +: COL_W] = e_col[j];
                    p[i]                = e_ipv[j];
                    ones                = ones + int'(e_ipv[j]);
                end
            end
            q_val.push_back(v);
            q_col.push_back(c);
            q_ipv.push_back(p);
            q_ones.push_back(ones);
        end

        // Idle: nnz_valid must be ignored before start.
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'(0));
        start       = 1'b0;
        nnz_valid   = 1'b1;
        nnz_val     = VAL_W'($urandom);
        nnz_col     = COL_W'($urandom);
        nnz_ipv     = 1'b1;
        nnz_last    = 1'b1;
        issue_ready = 1'b1;
        @(negedge clk);
        check("idle_valid_ignored_busy",  64'(busy),      64'(0));
        check("idle_valid_ignored_ready", 64'(nnz_ready), 64'(0));
        start = 1'b1;

        cyc = 0; idx = 0; fired = 0; last_fire = -100;
        hold = hold_cycles; pending = 1'b0; fin = 1'b0;
        while (!fin && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            exp_ready = (idx < n) && !pending;
            exp_done  = (fired == nb) && (cyc == last_fire + PIPE_DEPTH + 1);
            check("nnz_ready",   64'(nnz_ready),   64'(exp_ready));
            check("issue_valid", 64'(issue_valid), 64'(pending));
            check("done",        64'(done),        64'(exp_done));
            check("busy",        64'(busy),        64'(1));
            exp_bc = (fired > 255) ? 255 : fired;
            if (pending) begin
                check("issue_val",  64'(issue_val),  64'(q_val[0]));
                check("issue_col",  64'(issue_col),  64'(q_col[0]));
                check("issue_ipv",  64'(issue_ipv),  64'(q_ipv[0]));
                check("issue_ones", 64'(issue_ones), 64'(q_ones[0]));
                check("batch_count_issue", 64'(batch_count), 64'(exp_bc));
            end else begin
                check("issue_ones_idle", 64'(issue_ones), 64'(0));
            end
            if (exp_done) begin
                check("batch_count_final", 64'(batch_count), 64'(exp_bc));
                fin         = 1'b1;
                start       = 1'b0;
                nnz_valid   = 1'b0;
                issue_ready = 1'b0;
            end else begin
                start     = ($urandom_range(7) == 0);
                nnz_valid = ($urandom_range(99) < pv);
                if (idx < n) begin
                    nnz_val  = e_val[idx];
                    nnz_col  = e_col[idx];
                    nnz_ipv  = e_ipv[idx];
                    nnz_last = (idx == n - 1);
                end else begin
                    nnz_val  = VAL_W'($urandom);
                    nnz_col  = COL_W'($urandom);
                    nnz_ipv  = 1'($urandom);
                    nnz_last = 1'($urandom);
                end
                if (pending) begin
                    if (hold > 0) begin
                        issue_ready = 1'b0;
                        hold--;
                    end else begin
                        issue_ready = ($urandom_range(99) < pr);
                    end
                end else begin
                    issue_ready = 1'($urandom);
                end
                accepted = nnz_valid && exp_ready;
                fire     = issue_ready && pending;
                if (accepted) begin
                    if ((idx % K == K - 1) || (idx == n - 1)) pending = 1'b1;
                    idx++;
                end
                if (fire) begin
                    void'(q_val.pop_front());
                    void'(q_col.pop_front());
                    void'(q_ipv.pop_front());
                    void'(q_ones.pop_front());
                    fired++;
                    pending = 1'b0;
                    if (fired == nb) last_fire = cyc;
                end
            end
        end
        if (!fin) check("timeout", 64'(0), 64'(1));
        start       = 1'b0;
        nnz_valid   = 1'b0;
        issue_ready = 1'b0;
        @(negedge clk);
        check("post_done_busy",  64'(busy),        64'(0));
        check("post_done_done",  64'(done),        64'(0));
        check("post_done_ready", 64'(nnz_ready),   64'(0));
        check("post_done_valid", 64'(issue_valid), 64'(0));
    endtask

    // Accept two entries, then assert reset mid-batch.
    task automatic reset_mid_fill();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        nnz_valid = 1'b1;
        nnz_val   = 8'h5A;
        nnz_col   = 7'h33;
        nnz_ipv   = 1'b1;
        nnz_last  = 1'b0;
        check("rst_pre_ready", 64'(nnz_ready), 64'(1));
        @(negedge clk);
        nnz_val = 8'h7E;
        nnz_col = 7'h11;
        @(negedge clk);
        check("rst_pre_busy", 64'(busy), 64'(1));
        nnz_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid_fill");
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        nnz_valid   = 1'b0;
        nnz_val     = '0;
        nnz_col     = '0;
        nnz_ipv     = 1'b0;
        nnz_last    = 1'b0;
        issue_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Basic: two full batches.
        fill_random(8);
        run_matrix(8, 100, 100, 0);

        // Partial pad: values 1..5, second batch has one live lane.
        for (int i = 0; i < 5; i++) begin
            e_val[i] = VAL_W'(i + 1);
            e_col[i] = COL_W'(i + 10);
            e_ipv[i] = (i == 4);
        end
        run_matrix(5, 100, 100, 0);

        // IPV pattern 1,0,1,1 on lanes 0..3; last on lane K-1.
        fill_random(4);
        e_ipv[0] = 1'b1; e_ipv[1] = 1'b0; e_ipv[2] = 1'b1; e_ipv[3] = 1'b1;
        run_matrix(4, 100, 100, 0);

        // Back-pressure: issue_ready low for 3 ISSUE cycles.
        fill_random(4);
        run_matrix(4, 100, 100, 3);

        // Reset mid-FILL, then a single-entry matrix must show no stale lanes.
        reset_mid_fill();
        e_val[0] = 8'h01; e_col[0] = 7'h02; e_ipv[0] = 1'b0;
        run_matrix(1, 100, 100, 0);

        // Random matrices with random valid/ready duty.
        for (int t = 0; t < 20; t++) begin
            int n;
            n = int'($urandom_range(30, 1));
            fill_random(n);
            run_matrix(n, int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                       int'($urandom_range(3)));
        end

        // batch_count saturation at 255.
        fill_random(257 * K);
        run_matrix(257 * K, 100, 100, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/smvm_issue_scheduler.md
# smvm_issue_scheduler

Sequencer between the nonzero-entry input stream and the k-lane multiply/reduce tree of the SMVM engine.

- Accepts one (value, column, IPV) entry per handshake and packs entries into K-lane batches.
- Issues each batch to the tree with a valid/ready handshake and reports the IPV popcount for the output reducer.
- After the final entry, pads the last batch and waits out the tree's pipeline depth before signalling completion.

## Interface
- K, 4, lanes per batch (multiplier count)
- VAL_W, 8, signed matrix value width
- COL_W, 7, column index width (vector depth 2^COL_W = 128)
- PIPE_DEPTH, 4, tree latency in cycles from issue to result

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a matrix; sampled only in IDLE
- nnz_valid  in  1  entry available
- nnz_ready  out  1  entry accepted when nnz_valid && nnz_ready
- nnz_val  in  VAL_W  signed matrix value
- nnz_col  in  COL_W  column index
- nnz_ipv  in  1  1 = last nonzero of its row
- nnz_last  in  1  1 = last entry of the matrix
- issue_valid  out  1  batch presented to tree
- issue_ready  in  1  tree accepts batch
- issue_val  out  K*VAL_W  lane i at bits [VAL_W*(i+1)-1 -: VAL_W]
- issue_col  out  K*COL_W  same lane packing
- issue_ipv  out  K  bit i = lane i
- issue_ones  out  3  popcount of issue_ipv (0..K)
- batch_count  out  8  batches issued since start; saturates at 255
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of matrix

## Operation
States:
- IDLE: nnz_ready=0, issue_valid=0. start=1 → FILL, which also clears lane count, lane registers and batch_count.
- FILL: nnz_ready=1. Each accepted entry is written to lane[cnt] and cnt increments. The state moves to ISSUE on the accept where cnt==K-1 or nnz_last=1. A last_seen flag records nnz_last.
- ISSUE: nnz_ready=0, issue_valid=1, and lane outputs are stable. On issue_ready=1:
  - batch_count increments.
  - Lanes clear and cnt clears to 0.
  - Next state is DRAIN if last_seen, else FILL.
- DRAIN: drain counter runs 0..PIPE_DEPTH-1, then → DONE.
- DONE: done=1 for one cycle → IDLE. last_seen clears.

Data rules:
- Unfilled lanes in a partial batch are val=0, col=0, ipv=0.
- issue_ones is combinational popcount of issue_ipv. It is 0 whenever issue_valid=0.
- Lane 0 holds the first entry of the batch; entry order is preserved.

## Timing
- Reset (rst_n low at an edge) forces the following, including mid-batch or mid-drain. Any partial batch is discarded.
  - State IDLE.
  - nnz_ready=0, issue_valid=0, issue_val/col/ipv=0, issue_ones=0.
  - batch_count=0, busy=0, done=0.
- Full-rate throughput is K accept cycles + 1 issue cycle per batch when issue_ready=1.
- A FILL accept at edge t gives issue_valid high from t+1.
- Completion: the final issue handshake at edge t is followed by done high in cycle t+PIPE_DEPTH+1.
- issue_ready low: outputs hold unchanged and no entries are accepted (back-pressure upstream).
- start outside IDLE is ignored. nnz_valid outside FILL is ignored.
- nnz_last on lane K-1 produces exactly one full batch with no extra empty batch.
- nnz_last on the first entry produces one batch with a single live lane.

## Structure
- Package smvm_pkg holds K, VAL_W, COL_W, PIPE_DEPTH defaults and the state encoding (IDLE, FILL, ISSUE, DRAIN, DONE). The lane-count and drain-counter widths are derived from it.
- One sub-module: ipv_popcount (K-bit in, popcount out), shared with the output reducer.

## Test plan
- Basic: 8 entries, K=4, issue_ready=1, last on entry 8. Expect 2 batches, batch_count=2, and done at PIPE_DEPTH+1 cycles after the second issue.
- Partial pad: 5 entries with vals 1..5. Expect batch 2 to carry val lane0=5 with lanes1..3=0 and ipv=0.
- IPV count: batch with ipv pattern 1,0,1,1 (lanes 0..3). Expect issue_ipv=4'b1101 and issue_ones=3.
- Back-pressure: issue_ready low for 3 cycles during ISSUE. Expect outputs stable, nnz_ready=0 and batch_count unchanged, then the handshake completes.
- Reset mid-FILL: rst_n low after 2 accepts. Expect all outputs at reset values. A fresh start then issues a clean batch with no stale lanes.
- Ignored inputs: start pulsed in FILL and nnz_valid pulsed in IDLE. Expect no state change and no accepts.
